// File: rtl/param_seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops and a WIDTH-cycle shift-add multiply.
// Operands and op code are captured on start; results and flags are held until the next write.
module param_seq_alu #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpShl = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpIll = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CntW-1:0]      cnt_q;

    logic [WIDTH-1:0]     opa;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_carry;
    logic                 alu_err;
    logic [2*WIDTH-1:0]   mul_sum;
    logic                 mul_last;

    // Low half of the multiplicand register doubles as operand A for single-cycle ops.
    assign opa      = mcand_q[WIDTH-1:0];
    assign sum_ext  = {1'b0, opa} + {1'b0, mplier_q};
    assign diff_ext = {1'b0, opa} - {1'b0, mplier_q};
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CntLast);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_res[WIDTH:0] = sum_ext;
                alu_carry        = sum_ext[WIDTH];
            end
            OpSub: begin
                alu_res[WIDTH-1:0] = diff_ext[WIDTH-1:0];
                alu_carry          = diff_ext[WIDTH];
            end
            OpXor: alu_res[WIDTH-1:0] = opa ^ mplier_q;
            OpShl: begin
                alu_res[WIDTH:0] = {opa, 1'b0};
                alu_carry        = opa[WIDTH-1];
            end
            OpAnd: alu_res[WIDTH-1:0] = opa & mplier_q;
            OpOr:  alu_res[WIDTH-1:0] = opa | mplier_q;
            OpIll: alu_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (op == OpMul) ? StMul : StExec;
                end
            end
            StExec: state_d = StIdle;
            StMul: begin
                if (mul_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q     <= op;
                        mcand_q  <= {{WIDTH{1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StExec: begin
                    result <= alu_res;
                    carry  <= alu_carry;
                    zero   <= (alu_res == '0);
                    err    <= alu_err;
                    done   <= 1'b1;
                end
                StMul: begin
                    acc_q    <= mul_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (mul_last) begin
                        result <= mul_sum;
                        carry  <= 1'b0;
                        zero   <= (mul_sum == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, operand width in bits; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an operation.
REQ-005 Port op, input, 3 bits: function select.
REQ-006 Port a, input, WIDTH bits: operand A, unsigned.
REQ-007 Port b, input, WIDTH bits: operand B, unsigned.
REQ-008 Port busy, output, 1 bit: an operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse; result and flags valid.
REQ-010 Port result, output, 2*WIDTH bits: registered result.
REQ-011 Port carry, output, 1 bit: carry, borrow or shifted-out bit.
REQ-012 Port zero, output, 1 bit: result equals 0.
REQ-013 Port err, output, 1 bit: illegal op code.

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC and MUL.
REQ-015 When start is 1 in IDLE at a clock edge, the block SHALL latch a, b and op and move to EXEC, or to MUL if op=110.
REQ-016 After capture, later changes on a, b and op SHALL NOT affect the operation in progress.
REQ-017 start SHALL be ignored while busy=1; there is no queueing.
REQ-018 busy SHALL be 1 in EXEC and MUL, and 0 in IDLE.
REQ-019 EXEC SHALL last one cycle: on the next edge, result and flags are written, done goes to 1 and the state returns to IDLE.
REQ-020 MUL SHALL use shift-add over exactly WIDTH cycles: on the WIDTH-th edge after capture, result and flags are written, done goes to 1 and the state returns to IDLE.
REQ-021 done SHALL be high for exactly one cycle per operation.
REQ-022 A start during the done cycle SHALL be accepted, which gives back-to-back operation.
REQ-023 result, carry, zero and err SHALL hold their values until the next write.
REQ-024 op 000 (add): result[WIDTH:0] = A+B; carry = result[WIDTH].
REQ-025 op 001 (sub): result[WIDTH-1:0] = (A-B) mod 2^WIDTH; carry = 1 if A<B (borrow).
REQ-026 op 010 (xor): result[WIDTH-1:0] = A^B; carry = 0.
REQ-027 op 011 (shift left): result[WIDTH:0] = {A,0}; carry = A[WIDTH-1].
REQ-028 op 100 (and) and op 101 (or): result[WIDTH-1:0] = A&B or A|B respectively; carry = 0.
REQ-029 op 110 (multiply): result = A*B at full 2*WIDTH width; carry = 0.
REQ-030 op 111: result = 0, carry = 0, err = 1, with single-cycle EXEC latency.
REQ-031 err SHALL be 0 for every other op.
REQ-032 All result bits above the op's natural width SHALL be 0.
REQ-033 zero SHALL equal (written result == 0) and be updated with every result write.

Reset
REQ-034 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, result=0, carry=0, zero=0 and err=0, independent of clk.
REQ-035 Reset during EXEC or MUL SHALL abort the operation: no done pulse and no result write for it.
REQ-036 After rst is released, the first start edge SHALL be accepted normally.

Verification (WIDTH=3)
REQ-037 start, op=000, a=5, b=6 -> done on the 1st edge after capture; result=11, carry=1, zero=0, busy high 1 cycle.
REQ-038 op=001, a=2, b=5 -> result=5, carry=1; op=001, a=4, b=4 -> result=0, zero=1, carry=0.
REQ-039 op=110, a=7, b=7 -> busy high 3 cycles, done on the 3rd edge, result=49; a start with op=000 pulsed during cycle 2 is ignored.
REQ-040 op=110 started, rst pulsed in cycle 2 -> all outputs 0 at once, no done; a following op=011, a=6 -> result=12, carry=1.
REQ-041 op=111, a=3, b=1 -> result=0, zero=1, err=1; the next op=010, a=6, b=3 -> result=5, err=0.
REQ-042 Back-to-back: start held high across two operations -> second capture on the done edge, two distinct done pulses, correct results.
